// File: rtl/seg7_out_port.sv
// seg7_out_port: encodes a 16-bit word onto a 4-digit active-low 7-segment bus.
// The word is shown either as 4 hex digits or as 4 decimal digits. Decimal
// conversion is sequential double-dabble, one bit per clock. The display holds
// its value until the next accepted word.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  in_data/in_bcd valid this cycle
//   in_data   16-bit value to display
//   in_bcd    0 = hex display, 1 = decimal display
//   in_ready  port accepts a word this cycle (IDLE only)
//   busy      decimal conversion in progress (= ~in_ready)
//   overflow  last decimal word was > 9999
//   hex       segments, active-low, [27:21]=digit3 .. [6:0]=digit0, g..a per digit
module seg7_out_port #(
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_bcd,
  output logic        in_ready,
  output logic        busy,
  output logic        overflow,
  output logic [27:0] hex
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BCD_W  = 20;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HEX_W  = 28;
  localparam int unsigned SEG_W  = 7;

  localparam logic [HEX_W-1:0] HEX_RESET = 28'h8102040;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_bin,   w_bin_nxt;
  logic [BCD_W-1:0]    r_bcd,   w_bcd_nxt;
  logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
  logic [HEX_W-1:0]    r_hex,   w_hex_nxt;
  logic                r_ovf,   w_ovf_nxt;
  logic                r_ready, w_ready_nxt;
  logic [BCD_W+DATA_W-1:0] w_step;

  // Active-high segment code (g..a) of one hex digit.
  function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] d);
    logic [SEG_W-1:0] c;
    case (d)
      4'h0: c = 7'h3F;
      4'h1: c = 7'h06;
      4'h2: c = 7'h5B;
      4'h3: c = 7'h4F;
      4'h4: c = 7'h66;
      4'h5: c = 7'h6D;
      4'h6: c = 7'h7D;
      4'h7: c = 7'h07;
      4'h8: c = 7'h7F;
      4'h9: c = 7'h6F;
      4'hA: c = 7'h77;
      4'hB: c = 7'h7C;
      4'hC: c = 7'h39;
      4'hD: c = 7'h5E;
      4'hE: c = 7'h79;
      default: c = 7'h71;
    endcase
    return c;
  endfunction

  // Four nibbles to active-low segments, with optional leading-zero blanking.
  function automatic logic [HEX_W-1:0] encode(input logic [DATA_W-1:0] v);
    logic b3, b2, b1;
    logic [HEX_W-1:0] h;
    b3 = BLANK_LZ && (v[15:12] == 4'h0);
    b2 = b3 && (v[11:8] == 4'h0);
    b1 = b2 && (v[7:4] == 4'h0);
    h[27:21] = b3 ? SEG_BLANK : ~seg_code(v[15:12]);
    h[20:14] = b2 ? SEG_BLANK : ~seg_code(v[11:8]);
    h[13:7]  = b1 ? SEG_BLANK : ~seg_code(v[7:4]);
    h[6:0]   = ~seg_code(v[3:0]);
    return h;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left.
  function automatic logic [BCD_W+DATA_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                      input logic [DATA_W-1:0] bin);
    logic [BCD_W-1:0] adj;
    for (int n = 0; n < 5; n++) begin
      adj[n*4 +: 4] = (bcd[n*4 +: 4] >= 4'd5) ? (bcd[n*4 +: 4] + 4'd3) : bcd[n*4 +: 4];
    end
    return {adj, bin} << 1;
  endfunction

  assign w_step = dd_step(r_bcd, r_bin);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_hex   <= HEX_RESET;
      r_ovf   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_bcd   <= w_bcd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hex   <= w_hex_nxt;
      r_ovf   <= w_ovf_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_bcd_nxt   = r_bcd;
    w_cnt_nxt   = r_cnt;
    w_hex_nxt   = r_hex;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE: begin
        if (in_valid && r_ready) begin
          if (in_bcd) begin
            w_state_nxt = CONV;
            w_bin_nxt   = in_data;
            w_bcd_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_hex_nxt = encode(in_data);
            w_ovf_nxt = 1'b0;
          end
        end
      end
      CONV: begin
        w_bcd_nxt = w_step[BCD_W+DATA_W-1:DATA_W];
        w_bin_nxt = w_step[DATA_W-1:0];
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(15)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Results above 9999 show dashes on every digit, never blanked.
        if (r_bcd[19:16] != 4'h0) begin
          w_ovf_nxt = 1'b1;
          w_hex_nxt = {4{~SEG_DASH}};
        end else begin
          w_ovf_nxt = 1'b0;
          w_hex_nxt = encode(r_bcd[15:0]);
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == IDLE);
  end

  assign in_ready = r_ready;
  assign busy     = ~r_ready;
  assign overflow = r_ovf;
  assign hex      = r_hex;

endmodule

// File: tb/tb_seg7_out_port.sv
module tb_seg7_out_port;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_bcd;
  logic        rdy0, bsy0, ovf0, rdy1, bsy1, ovf1;
  logic [27:0] hex0, hex1;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp0, exp1;
  logic        exp_ovf;

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam int unsigned PW10 [4] = '{1, 10, 100, 1000};

  seg7_out_port #(.BLANK_LZ(1'b0)) u_plain (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_bcd(in_bcd),
    .in_ready(rdy0), .busy(bsy0), .overflow(ovf0), .hex(hex0)
  );

  seg7_out_port #(.BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_bcd(in_bcd),
    .in_ready(rdy1), .busy(bsy1), .overflow(ovf1), .hex(hex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display from digit arithmetic: hex nibbles or decimal digits.
  function automatic logic [27:0] model(input int unsigned v, input bit dec, input bit blank);
    logic [27:0] r;
    int unsigned d;
    bit lead;
    if (dec && v > 9999) return {4{~7'h40}};
    lead = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      d = dec ? (v / PW10[i]) % 10 : (v >> (4 * i)) & 15;
      if (blank && lead && d == 0 && i != 0) begin
        r[i*7 +: 7] = 7'h7F;
      end else begin
        lead = 1'b0;
        r[i*7 +: 7] = ~SEG[4'(d)];
      end
    end
    return r;
  endfunction

  task automatic chk_hex(input string tag, input logic [27:0] obs, input logic [27:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    chk_hex({tag, ".hex0"}, hex0, exp0);
    chk_hex({tag, ".hex1"}, hex1, exp1);
    chk_bit({tag, ".rdy0"}, rdy0, 1'b1);
    chk_bit({tag, ".rdy1"}, rdy1, 1'b1);
    chk_bit({tag, ".bsy0"}, bsy0, 1'b0);
    chk_bit({tag, ".ovf0"}, ovf0, exp_ovf);
    chk_bit({tag, ".ovf1"}, ovf1, exp_ovf);
  endtask

  // Entered and left at a falling edge.
  task automatic send_hex(input logic [15:0] v, input string tag);
    in_valid = 1'b1; in_data = v; in_bcd = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    exp0 = model(v, 1'b0, 1'b0);
    exp1 = model(v, 1'b0, 1'b1);
    exp_ovf = 1'b0;
    check_idle(tag);
  endtask

  // poke: busy cycle (1..17) at which a stray word is offered; rst_at: cycle to reset (0 = none).
  task automatic send_dec(input logic [15:0] v, input int poke, input int rst_at, input string tag);
    in_valid = 1'b1; in_data = v; in_bcd = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        exp0 = 28'h8102040; exp1 = 28'h8102040; exp_ovf = 1'b0;
        check_idle({tag, ".inrst"});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle({tag, ".postrst"});
        return;
      end
      chk_bit({tag, ".busy_rdy"}, rdy0, 1'b0);
      chk_bit({tag, ".busy_rdy1"}, rdy1, 1'b0);
      chk_bit({tag, ".busy"}, bsy0, 1'b1);
      chk_hex({tag, ".hold0"}, hex0, exp0);
      chk_hex({tag, ".hold1"}, hex1, exp1);
      if (i == poke) begin
        in_valid = 1'b1; in_data = 16'hFFFF; in_bcd = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
    end
    exp0 = model(v, 1'b1, 1'b0);
    exp1 = model(v, 1'b1, 1'b1);
    exp_ovf = (v > 16'd9999);
    check_idle(tag);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] edge_vals [6];
    edge_vals = '{16'd0, 16'd9999, 16'd10000, 16'hFFFF, 16'd1000, 16'd9};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bcd = 1'b0;
    exp0 = 28'h8102040; exp1 = 28'h8102040; exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    send_hex(16'h12AF, "t2_hex");
    chk_hex("t2_const", hex0, {~7'h06, ~7'h5B, ~7'h77, ~7'h71});

    send_dec(16'd1234, 0, 0, "t3_dec");
    chk_hex("t3_const", hex0, {~7'h06, ~7'h5B, ~7'h4F, ~7'h66});

    send_dec(16'd10000, 0, 0, "t4_ovf");
    chk_hex("t4_dash", hex1, {4{~7'h40}});
    send_hex(16'h0000, "t4_clear");

    send_hex(16'h0005, "t5_5");
    chk_hex("t5_5_const", hex1, {21'h1FFFFF, ~7'h6D});
    send_hex(16'h0000, "t5_0");
    send_dec(16'd907, 0, 0, "t5_907");
    chk_hex("t5_907_const", hex1, {7'h7F, ~7'h6F, ~7'h3F, ~7'h07});

    send_dec(16'd42, 3, 0, "t6_poke");
    send_dec(16'd42, 17, 0, "t6_poke_done");
    send_dec(16'd4321, 0, 8, "t6_rst");

    // Back-to-back hex accepts every cycle.
    for (int i = 0; i < 8; i++) begin
      send_hex(16'($urandom), "b2b_hex");
    end

    for (int i = 0; i < 6; i++) begin
      send_dec(edge_vals[i], 0, 0, "edge_dec");
    end

    for (int i = 0; i < 20; i++) begin
      v = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 12000)) : 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        send_hex(v, "rnd_hex");
      end else begin
        send_dec(v, int'($urandom_range(0, 17)), 0, "rnd_dec");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
